// File: rtl/cone_sig_pkg.sv
// Shared types and helpers for the cone signature compactor.
package cone_sig_pkg;

    // Capture-run controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default feedback taps (CRC-16-CCITT style) and start value
    localparam logic [15:0] CONE_SIG_POLY = 16'h1021;
    localparam logic [15:0] CONE_SIG_SEED = 16'h0000;

    // Widest signature the step helper supports; callers zero-extend into it
    localparam int SIG_MAX_W = 64;

    // One MISR step: shift left, fold the MSB back through the taps, then
    // inject the new bit at position 0. Only the low 'width' bits are meaningful.
    function automatic logic [SIG_MAX_W-1:0] misr_step(
        input logic [SIG_MAX_W-1:0] sig,
        input logic                 din,
        input logic [SIG_MAX_W-1:0] poly,
        input int                   width
    );
        logic [SIG_MAX_W-1:0] mask;
        logic [SIG_MAX_W-1:0] nxt;
        logic                 fb;
        mask = '0;
        fb   = 1'b0;
        for (int i = 0; i < SIG_MAX_W; i++) begin
            mask[i] = (i < width);
            if (i == width - 1) begin
                fb = sig[i];
            end
        end
        nxt = (sig << 1) & mask;
        if (fb) begin
            nxt = nxt ^ (poly & mask);
        end
        nxt[0] = nxt[0] ^ din;
        return nxt;
    endfunction

endpackage

// File: rtl/cone_sig_compactor_misr_reg.sv
// Signature register: reseeds on load, advances one MISR step on en.
module misr_reg
    import cone_sig_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(CONE_SIG_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(CONE_SIG_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] q
);

    logic [SIG_W-1:0] r_q;
    logic [SIG_W-1:0] w_next;

    assign w_next = SIG_W'(misr_step(SIG_MAX_W'(r_q), din, SIG_MAX_W'(POLY), SIG_W));
    assign q      = r_q;

    // Reset and load both reseed; otherwise step only on an enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= w_next;
        end
    end

endmodule

// File: rtl/cone_sig_compactor.sv
// Capture stage for a logic cone output: compacts a programmed number of
// bits into a MISR signature, counts ones, and hands the result off with
// a valid/ready handshake.
module cone_sig_compactor
    import cone_sig_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(CONE_SIG_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(CONE_SIG_SEED),
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] ones_count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_ones;

    logic w_start_acc;
    logic w_accept;
    logic w_last;

    // start only matters in IDLE; in_valid only matters in RUN
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_RUN) && in_valid;
    assign w_last      = w_accept && (r_cnt == r_num - 1'b1);

    // State register; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs (no input-to-output paths)
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        done_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sample counter, latched length and saturating ones counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_num  <= '0;
            r_ones <= '0;
        end else if (w_start_acc) begin
            r_cnt  <= '0;
            r_num  <= num_samples;
            r_ones <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (in_bit && (r_ones != {CNT_W{1'b1}})) begin
                r_ones <= r_ones + 1'b1;
            end
        end
    end

    assign ones_count = r_ones;

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_acc),
        .en   (w_accept),
        .din  (in_bit),
        .q    (signature)
    );

endmodule

// File: tb/tb_cone_sig_compactor.sv
// Self-checking bench for cone_sig_compactor: directed and randomized runs
// compared against a bit-serial arithmetic model of the signature.
module tb_cone_sig_compactor;

    localparam int SIG_W = 16;
    localparam int CNT_W = 8;
    localparam int POLY_I = 'h1021;
    localparam int SEED_I = 'h0000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] ones_count;

    int checks;
    int failures;
    int last_sig;

    cone_sig_compactor #(
        .SIG_W (SIG_W),
        .POLY  (16'h1021),
        .SEED  (16'h0000),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .signature   (signature),
        .ones_count  (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Signature as polynomial arithmetic: multiply by x mod 2^16, reduce the
    // overflowing x^16 term by the taps, then add the incoming bit.
    function automatic int model_next(input int s, input int b);
        int t;
        t = s * 2;
        if (t >= 65536) t = (t - 65536) ^ POLY_I;
        return t ^ b;
    endfunction

    // gap: 0 = contiguous, 1 = toggle, 2 = random; noise drives start while busy
    task automatic do_run(input int n, input logic [255:0] bits, input int gap,
                          input int hold, input bit noise, input string tag);
        int exp_sig;
        int exp_ones;
        int idx;
        int cyc;
        int budget;
        bit iv;
        bit acc;
        exp_sig  = SEED_I;
        exp_ones = 0;
        idx      = 0;
        cyc      = 0;
        budget   = 4 * n + 20;
        start = 1'b1;
        num_samples = CNT_W'(n);
        step();
        start = noise;
        num_samples = CNT_W'($urandom_range(1, 200));
        check({tag, "_busy_after_start"}, int'(busy), 1);
        check({tag, "_ready_after_start"}, int'(in_ready), (n != 0) ? 1 : 0);
        check({tag, "_seed"}, int'(signature), SEED_I);
        while (idx < n && cyc < budget) begin
            case (gap)
                0: iv = 1'b1;
                1: iv = ((cyc % 2) == 0);
                default: iv = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = iv;
            in_bit   = bits[idx];
            acc      = iv && in_ready;
            step();
            cyc++;
            if (acc) begin
                exp_sig = model_next(exp_sig, int'(bits[idx]));
                exp_ones += int'(bits[idx]);
                idx++;
                check({tag, "_sig_step"}, int'(signature), exp_sig);
            end
            if (idx < n) check({tag, "_ready_run"}, int'(in_ready), 1);
        end
        in_valid = 1'b0;
        check({tag, "_accepts"}, idx, n);
        check({tag, "_done_valid"}, int'(done_valid), 1);
        check({tag, "_ready_done"}, int'(in_ready), 0);
        check({tag, "_sig"}, int'(signature), exp_sig);
        check({tag, "_ones"}, int'(ones_count), exp_ones);
        done_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, "_hold_valid"}, int'(done_valid), 1);
            check({tag, "_hold_sig"}, int'(signature), exp_sig);
            check({tag, "_hold_ones"}, int'(ones_count), exp_ones);
        end
        done_ready = 1'b1;
        start = noise;
        step();
        done_ready = 1'b0;
        start = 1'b0;
        check({tag, "_idle_valid"}, int'(done_valid), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_sig"}, int'(signature), exp_sig);
        last_sig = exp_sig;
    endtask

    initial begin
        logic [255:0] b;
        int n;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        done_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_sig", int'(signature), SEED_I);
        check("rst_ones", int'(ones_count), 0);
        rst = 1'b0;
        step();

        // Basic run: bits 1,0,0,0
        b = '0;
        b[0] = 1'b1;
        do_run(4, b, 0, 0, 1'b0, "basic");
        check("basic_const_sig", int'(signature), 'h0008);
        check("basic_const_ones", int'(ones_count), 1);

        // Feedback wrap through the taps
        b = '1;
        do_run(17, b, 0, 0, 1'b0, "feedback");
        check("feedback_const_sig", int'(signature), 'hEFDE);
        check("feedback_const_ones", int'(ones_count), 17);

        // Zero-length run
        do_run(0, b, 0, 0, 1'b0, "zero");
        check("zero_sig", int'(signature), 'h0000);
        check("zero_ones", int'(ones_count), 0);

        // Gapped input and held-off consumer, with start noise while busy
        b = '0;
        b[0] = 1'b1;
        do_run(4, b, 1, 5, 1'b1, "gaps");
        check("gaps_const_sig", int'(signature), 'h0008);

        // in_valid while IDLE must not disturb the held signature
        in_valid = 1'b1;
        in_bit = 1'b1;
        step();
        step();
        step();
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_sig_hold", int'(signature), last_sig);
        in_valid = 1'b0;

        // Reset mid-run after two accepts
        start = 1'b1;
        num_samples = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        step();
        in_bit = 1'b0;
        step();
        in_valid = 1'b0;
        check("mid_sig_before_rst", int'(signature), 'h0002);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(in_ready), 0);
        check("mid_rst_sig", int'(signature), SEED_I);
        check("mid_rst_ones", int'(ones_count), 0);
        b = '0;
        b[0] = 1'b1;
        do_run(4, b, 0, 0, 1'b0, "after_rst");
        check("after_rst_const", int'(signature), 'h0008);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < 256; i++) b[i] = 1'($urandom_range(0, 1));
            do_run(n, b, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
